// File: rtl/dpll_trim_controller_if.sv
// Control/trim bundle between the loop controller and its environment.
// The master drives the reference clock, ratio and bypass inputs; the slave returns the trim state.
interface dpll_trim_controller_if;
  logic        osc;
  logic [4:0]  div;
  logic        dco;
  logic [25:0] ext_trim;
  logic [25:0] trim;
  logic [4:0]  tval;
  logic        locked;

  modport master (
    output osc, div, dco, ext_trim,
    input  trim, tval, locked
  );

  modport slave (
    input  osc, div, dco, ext_trim,
    output trim, tval, locked
  );
endinterface

// File: rtl/dpll_trim_controller.sv
// Frequency-locking trim controller for a 13-stage ring oscillator.
// Counts oscillator cycles per reference period and steps a thermometer trim code.
module dpll_trim_controller #(
  parameter int unsigned TOL       = 1,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned INIT_TVAL = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  dpll_trim_controller_if.slave bus
);

  localparam int unsigned LockW    = $clog2(LOCK_CNT + 1);
  localparam logic [63:0] TrimFull = (64'd1 << INIT_TVAL) - 64'd1;
  localparam logic [25:0] TrimInit = TrimFull[25:0];

  typedef enum logic [1:0] {StWait0, StWait1, StTrack} state_e;

  state_e             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic [6:0]         cnt_q, cnt_d;
  logic [6:0]         prev_q, prev_d;
  logic [4:0]         tval_q, tval_d;
  logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [25:0]        trim_q, trim_d;
  logic               locked_q, locked_d;

  logic               edge_det;
  logic [7:0]         sum, tgt;
  logic               too_fast, too_slow;
  logic [25:0]        therm;

  always_comb begin
    edge_det = s2_q & ~s3_q;
    cnt_d    = edge_det ? 7'd1 : ((cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1);

    // On an edge cycle cnt_q holds the cycle count of the period just ended.
    sum      = {1'b0, prev_q} + {1'b0, cnt_q};
    tgt      = {2'b00, bus.div, 1'b0};
    too_fast = sum > (tgt + 8'(TOL));
    too_slow = (sum + 8'(TOL)) < tgt;

    state_d    = state_q;
    prev_d     = prev_q;
    tval_d     = tval_q;
    lock_cnt_d = lock_cnt_q;

    if (bus.dco) begin
      state_d    = StWait0;
      lock_cnt_d = '0;
    end else if (edge_det) begin
      case (state_q)
        StWait0: state_d = StWait1;
        StWait1: begin
          prev_d  = cnt_q;
          state_d = StTrack;
        end
        StTrack: begin
          prev_d = cnt_q;
          if (bus.div == 5'd0) begin
            lock_cnt_d = '0;
          end else if (too_fast) begin
            if (tval_q < 5'd26) tval_d = tval_q + 5'd1;
            lock_cnt_d = '0;
          end else if (too_slow) begin
            if (tval_q != 5'd0) tval_d = tval_q - 5'd1;
            lock_cnt_d = '0;
          end else if (lock_cnt_q < LockW'(LOCK_CNT)) begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
          end
        end
        default: state_d = StWait0;
      endcase
    end

    for (int i = 0; i < 26; i++) begin
      therm[i] = (5'(i) < tval_q);
    end
    trim_d   = bus.dco ? bus.ext_trim : therm;
    locked_d = (lock_cnt_q == LockW'(LOCK_CNT)) && !bus.dco && (state_q == StTrack);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      cnt_q      <= '0;
      prev_q     <= '0;
      state_q    <= StWait0;
      tval_q     <= 5'(INIT_TVAL);
      lock_cnt_q <= '0;
      trim_q     <= TrimInit;
      locked_q   <= 1'b0;
    end else begin
      s1_q       <= bus.osc;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      tval_q     <= tval_d;
      lock_cnt_q <= lock_cnt_d;
      trim_q     <= trim_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.trim   = trim_q;
  assign bus.tval   = tval_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_dpll_trim_controller.sv
// Bench for dpll_trim_controller: directed phases then randomized periods,
// checked against a per-reference-edge model of the trim loop.
module tb_dpll_trim_controller;

  localparam int TOL   = 1;
  localparam int LOCKN = 4;
  localparam int INIT  = 13;

  logic clock = 1'b0;
  logic reset;

  dpll_trim_controller_if bus ();

  dpll_trim_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Model state: 0 = waiting first edge, 1 = waiting second edge, 2 = tracking.
  int m_state, m_prev, m_tval, m_lock, last_t;

  function automatic logic [25:0] therm(int t);
    logic [63:0] v;
    v = (64'd1 << t) - 64'd1;
    return v[25:0];
  endfunction

  function automatic logic [25:0] exp_trim();
    return bus.dco ? bus.ext_trim : therm(m_tval);
  endfunction

  function automatic logic exp_locked();
    return !bus.dco && (m_lock == LOCKN) && (m_state == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_prev  = 0;
    m_tval  = INIT;
    m_lock  = 0;
    last_t  = 0;
  endtask

  task automatic model_edge(input int per);
    int sum, tgt;
    if (bus.dco) begin
      m_state = 0;
      m_lock  = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_prev  = per;
      m_state = 2;
    end else begin
      sum = m_prev + per;
      tgt = 2 * int'(bus.div);
      if (bus.div == 5'd0) m_lock = 0;
      else if (sum > tgt + TOL) begin
        if (m_tval < 26) m_tval++;
        m_lock = 0;
      end else if (sum + TOL < tgt) begin
        if (m_tval > 0) m_tval--;
        m_lock = 0;
      end else if (m_lock < LOCKN) m_lock++;
      m_prev = per;
    end
  endtask

  task automatic set_dco(input logic v, input logic [25:0] ext);
    bus.dco      = v;
    bus.ext_trim = ext;
    if (v) begin
      m_state = 0;
      m_lock  = 0;
    end
  endtask

  // One reference period of t clocks, osc high for the first hi clocks.
  task automatic run_period(input int t, input int hi);
    logic [25:0] old_trim;
    logic        old_locked;
    int          per;
    per     = (last_t > 127) ? 127 : last_t;
    bus.osc = 1'b1;
    for (int i = 0; i < t; i++) begin
      if (i == hi) bus.osc = 1'b0;
      @(posedge clock);
      #1;
      if (i == 0) begin
        chk("trim_c1", 32'(bus.trim), 32'(exp_trim()));
        chk("locked_c1", 32'(bus.locked), 32'(exp_locked()));
      end
      if (i == 2) begin
        old_trim   = exp_trim();
        old_locked = exp_locked();
        model_edge(per);
        chk("tval_c3", 32'(bus.tval), 32'(m_tval));
        chk("trim_c3_old", 32'(bus.trim), 32'(old_trim));
        chk("locked_c3_old", 32'(bus.locked), 32'(old_locked));
      end
      if (i == 3) begin
        chk("trim_c4", 32'(bus.trim), 32'(exp_trim()));
        chk("locked_c4", 32'(bus.locked), 32'(exp_locked()));
        chk("tval_c4", 32'(bus.tval), 32'(m_tval));
      end
      if (i == t - 1 && t >= 140) chk("cnt_sat", 32'(dut.cnt_q), 32'd127);
    end
    last_t = t;
  endtask

  initial begin
    int t;
    bus.osc      = 1'b0;
    bus.div      = 5'd20;
    bus.dco      = 1'b0;
    bus.ext_trim = '0;
    reset        = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst_trim", 32'(bus.trim), 32'h0001FFF);
      chk("rst_tval", 32'(bus.tval), 32'd13);
      chk("rst_locked", 32'(bus.locked), 32'd0);
    end
    reset = 1'b0;

    repeat (8) run_period(20, 10);
    chk("lock_div20", 32'(bus.locked), 32'd1);
    chk("lock_tval", 32'(bus.tval), 32'd13);

    repeat (18) run_period(30, 15);
    chk("fast_tval_sat", 32'(bus.tval), 32'd26);
    chk("fast_trim_sat", 32'(bus.trim), 32'h3FFFFFF);

    repeat (30) run_period(10, 5);
    chk("slow_tval_sat", 32'(bus.tval), 32'd0);
    chk("slow_trim_sat", 32'(bus.trim), 32'h0000000);
    repeat (8) run_period(20, 10);
    chk("relock", 32'(bus.locked), 32'd1);

    set_dco(1'b1, 26'h1555555);
    repeat (2) run_period(20, 10);
    chk("dco_trim", 32'(bus.trim), 32'h1555555);
    chk("dco_locked", 32'(bus.locked), 32'd0);
    set_dco(1'b0, 26'h1555555);
    repeat (7) run_period(20, 10);
    chk("dco_relock", 32'(bus.locked), 32'd1);

    run_period(220, 10);
    repeat (8) run_period(20, 10);

    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    chk("mid_rst_trim", 32'(bus.trim), 32'h0001FFF);
    chk("mid_rst_tval", 32'(bus.tval), 32'd13);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
    reset = 1'b0;
    repeat (8) run_period(20, 10);

    repeat (150) begin
      case ($urandom_range(0, 19))
        0: set_dco(~bus.dco, 26'($urandom));
        1: bus.div = 5'($urandom_range(6, 31));
        2: bus.div = 5'd0;
        default: ;
      endcase
      t = int'(bus.div) + int'($urandom_range(0, 6)) - 3;
      if (t < 8) t = 8;
      run_period(t, t / 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
